mux_pipe_skid: RTL

//  Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_sel_comb.sv | 26 ++
 rtl/mux_pipe_skid.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types for the registered channel mux: FSM state encoding and out-of-range fill value.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } mux_state_t;

    // Fill bit replicated across the word when the select names no channel.
    localparam logic OOR_FILL_BIT = 1'b0;

endpackage : mux_pkg

// File: rtl/mux_sel_comb.sv
// N:1 W-bit combinational selector; a select past the last channel yields an all-zero word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns any handshake.
module mux_sel_comb
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 2,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] in_i,
    input  logic [SELW-1:0]           sel_i,
    output logic [WIDTH-1:0]          dat_o
);

    // Compare against each legal index so no part-select can fall off the bus.
    always_comb begin
        dat_o = {WIDTH{OOR_FILL_BIT}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_i == SELW'(k)) begin
                dat_o = in_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux_sel_comb

// File: rtl/mux_pipe_skid.sv
// Registered N:1 mux with valid/ready handshake and a 2-entry (main + skid) buffer; MUX_PARITY_EN adds o_par_o.
// Latency: 1 cycle from accepted beat to o_vld_o when empty.
// Backpressure: absorbs one stalled beat in the skid reg; in_rdy_o comes from registered state only.
module mux_pipe_skid
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 2,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [CHANNELS*WIDTH-1:0] in_i,
    input  logic [SELW-1:0]           sel_i,
    input  logic                      in_vld_i,
    output logic                      in_rdy_o,
    output logic [WIDTH-1:0]          o_dat_o,
    output logic                      o_vld_o,
    input  logic                      o_rdy_i
`ifdef MUX_PARITY_EN
    ,
    output logic                      o_par_o
`endif
);

    mux_state_t       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] sel_dat;
    logic             push;
    logic             pop;

    mux_sel_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_sel (
        .in_i  (in_i),
        .sel_i (sel_i),
        .dat_o (sel_dat)
    );

    assign in_rdy_o = (state_q != FULL);
    assign o_vld_o  = (state_q != EMPTY);
    assign o_dat_o  = main_q;
    assign push     = in_vld_i & in_rdy_o;
    assign pop      = o_vld_o & o_rdy_i;

`ifdef MUX_PARITY_EN
    logic par_main_q, par_main_d;
    logic par_skid_q, par_skid_d;
    logic sel_par;

    assign sel_par = ^sel_dat;
    assign o_par_o = par_main_q;
`endif

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
`ifdef MUX_PARITY_EN
        par_main_d = par_main_q;
        par_skid_d = par_skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (push) begin
                    main_d  = sel_dat;
                    state_d = ONE;
`ifdef MUX_PARITY_EN
                    par_main_d = sel_par;
`endif
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_d = sel_dat;
`ifdef MUX_PARITY_EN
                    par_main_d = sel_par;
`endif
                end else if (push) begin
                    skid_d  = sel_dat;
                    state_d = FULL;
`ifdef MUX_PARITY_EN
                    par_skid_d = sel_par;
`endif
                end else if (pop) begin
                    state_d = EMPTY;
`ifdef MUX_PARITY_EN
                    // Parity reads 0 whenever nothing is held.
                    par_main_d = 1'b0;
`endif
                end
            end
            FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
`ifdef MUX_PARITY_EN
                    par_main_d = par_skid_q;
`endif
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_main_q <= 1'b0;
            par_skid_q <= 1'b0;
        end else begin
            par_main_q <= par_main_d;
            par_skid_q <= par_skid_d;
        end
    end
`endif

endmodule : mux_pipe_skid
